// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - Lock/soft-reset inputs and reset/status outputs of the reset sequencer
// slave modport is the sequencer side; master modport is the environment driving lock and soft reset.
interface rst_sequencer_if #(
   parameter int N_CH = 4
);
   logic            iPLL_LOCKED;
   logic            iSOFT_RST;
   logic [N_CH-1:0] oRST;
   logic            oREADY;
   logic [2:0]      oSTATE;

   modport slave (
      input  iPLL_LOCKED,
      input  iSOFT_RST,
      output oRST,
      output oREADY,
      output oSTATE
   );

   modport master (
      output iPLL_LOCKED,
      output iSOFT_RST,
      input  oRST,
      input  oREADY,
      input  oSTATE
   );
endinterface

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - Multi-channel reset sequencer: lock filter, init delay, staggered in-order release
// Optional RST_SEQ_REVERSE_ASSERT_EN: soft reset re-asserts channels in reverse order through DRAIN.
module rst_sequencer #(
   parameter int N_CH      = 4,
   parameter int LOCK_FILT = 8,
   parameter int INIT_CYC  = 32,
   parameter int STAGGER   = 16
) (
   input  logic           iCLK,
   input  logic           iRESET,
   rst_sequencer_if.slave bus
);
   localparam int MAX_A = (LOCK_FILT > INIT_CYC) ? LOCK_FILT : INIT_CYC;
   localparam int MAX_B = (STAGGER > N_CH) ? STAGGER : N_CH;
   localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_V) + 1;

   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic [CW-1:0] LF_LAST   = CW'(LOCK_FILT - 1);
   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYC - 1);
   localparam logic [CW-1:0] STG_LAST  = CW'(STAGGER - 1);
   localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);
`ifdef RST_SEQ_REVERSE_ASSERT_EN
   localparam logic [CW-1:0] CH_DRAIN0 = CW'(N_CH - 2);
`endif

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_WAIT    = 3'd1,
      S_RELEASE = 3'd2,
      S_RUN     = 3'd3
`ifdef RST_SEQ_REVERSE_ASSERT_EN
      , S_DRAIN = 3'd4
`endif
   } state_t;

   state_t          r_state, w_nxt_state;
   logic [CW-1:0]   r_cnt, w_cnt;
   logic [CW-1:0]   r_ch, w_ch;
   logic [N_CH-1:0] r_rst, w_rst;
   logic            r_ready, w_ready;
   logic [N_CH-1:0] w_sel;

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_ch    <= '0;
         r_rst   <= '1;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_cnt;
         r_ch    <= w_ch;
         r_rst   <= w_rst;
         r_ready <= w_ready;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_cnt       = r_cnt;
      w_ch        = r_ch;
      w_rst       = r_rst;
      w_ready     = r_ready;
      for (int k = 0; k < N_CH; k++) begin
         w_sel[k] = (CW'(k) == r_ch);
      end

      if ((r_state != S_HOLD) && !bus.iPLL_LOCKED) begin
         w_nxt_state = S_HOLD;
         w_cnt       = '0;
         w_ch        = '0;
         w_rst       = '1;
         w_ready     = 1'b0;
      end else begin
         case (r_state)
            S_HOLD: begin
               w_rst   = '1;
               w_ready = 1'b0;
               if (!bus.iPLL_LOCKED) begin
                  w_cnt = '0;
               end else if (r_cnt >= LF_LAST) begin
                  w_nxt_state = S_WAIT;
                  w_cnt       = '0;
               end else begin
                  w_cnt = r_cnt + ONE;
               end
            end
            S_WAIT: begin
               if (r_cnt == INIT_LAST) begin
                  w_cnt = '0;
                  w_ch  = ONE;
                  w_rst = {N_CH{1'b1}} << 1;
                  if (N_CH == 1) begin
                     w_nxt_state = S_RUN;
                     w_ready     = 1'b1;
                  end else begin
                     w_nxt_state = S_RELEASE;
                  end
               end else begin
                  w_cnt = r_cnt + ONE;
               end
            end
            S_RELEASE: begin
               if (r_cnt == STG_LAST) begin
                  w_cnt = '0;
                  w_rst = r_rst & ~w_sel;
                  if (r_ch == CH_LAST) begin
                     w_nxt_state = S_RUN;
                     w_ready     = 1'b1;
                     w_ch        = '0;
                  end else begin
                     w_ch = r_ch + ONE;
                  end
               end else begin
                  w_cnt = r_cnt + ONE;
               end
            end
            S_RUN: begin
               w_rst   = '0;
               w_ready = 1'b1;
               // Lock is known high on this edge, so it already counts as the first qualifying sample.
               if (bus.iSOFT_RST) begin
                  w_ready = 1'b0;
                  w_ch    = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
                  if (N_CH == 1) begin
                     w_nxt_state = S_HOLD;
                     w_rst       = '1;
                     w_cnt       = ONE;
                  end else begin
                     w_nxt_state      = S_DRAIN;
                     w_rst            = '0;
                     w_rst[N_CH-1]    = 1'b1;
                     w_cnt            = '0;
                     w_ch             = CH_DRAIN0;
                  end
`else
                  w_nxt_state = S_HOLD;
                  w_rst       = '1;
                  w_cnt       = ONE;
`endif
               end
            end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            S_DRAIN: begin
               w_ready = 1'b0;
               if (r_cnt == STG_LAST) begin
                  w_cnt = '0;
                  w_rst = r_rst | w_sel;
                  if (r_ch == '0) begin
                     w_nxt_state = S_HOLD;
                     w_cnt       = ONE;
                  end else begin
                     w_ch = r_ch - ONE;
                  end
               end else begin
                  w_cnt = r_cnt + ONE;
               end
            end
`endif
            default: begin
               w_nxt_state = S_HOLD;
               w_cnt       = '0;
               w_ch        = '0;
               w_rst       = '1;
               w_ready     = 1'b0;
            end
         endcase
      end
   end

   assign bus.oRST   = r_rst;
   assign bus.oREADY = r_ready;
   assign bus.oSTATE = r_state;
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised successor to the top-level power-on reset counter. A single 6-bit counter with one implicit reset becomes a multi-channel reset sequencer.
- Holds all downstream domains (SDRAM controller, video pipe, user design, etc.) in reset until the system PLL lock is stable.
- Waits an init delay, then releases the channels one by one in order, with a fixed stagger between releases.
- Supports a soft-reset request that re-runs the full sequence. Lives in the top level, clocked by the memory/system clock.

Parameters:
- N_CH, 4, number of reset channels (1..16).
- LOCK_FILT, 8, consecutive cycles iPLL_LOCKED must be sampled high before leaving HOLD (≥1).
- INIT_CYC, 32, cycles spent in WAIT after lock is qualified (≥1).
- STAGGER, 16, cycles between successive channel releases or assertions (≥1).

Ports:
- iCLK  in  1  system clock; all logic is on its rising edge.
- iRESET  in  1  synchronous, active-high reset.
- iPLL_LOCKED  in  1  PLL lock; already synchronous to iCLK.
- iSOFT_RST  in  1  soft-reset request; single-cycle pulse or level; only sampled in RUN.
- oRST  out  N_CH  per-channel reset, active-high, registered.
- oREADY  out  1  high only in RUN (all channels released), registered.
- oSTATE  out  3  current state: HOLD=0, WAIT=1, RELEASE=2, RUN=3, DRAIN=4.

Behaviour:
- Clocking and reset
  - One clock domain. Reset is synchronous and active-high, named iRESET; clock is iCLK.
  - iRESET=1 at an edge gives, on that edge: oRST all ones, oREADY=0, state HOLD, all counters 0. iRESET overrides every other input.
  - Internal counter width is $clog2 of the largest of LOCK_FILT, INIT_CYC, STAGGER, N_CH, plus 1. There is no wrap-around: each counter is cleared on every state entry.
- HOLD
  - oRST all ones.
  - Lock counter increments on each edge with iPLL_LOCKED=1 and clears on any edge with iPLL_LOCKED=0.
  - On the edge where the LOCK_FILT-th consecutive high sample is taken, go to WAIT.
- WAIT
  - oRST all ones. Counts INIT_CYC edges.
  - On the INIT_CYC-th edge, go to RELEASE and clear oRST[0] on that same edge (edge E0).
- RELEASE
  - oRST[k] clears at edge E0 + k*STAGGER.
  - On the edge that clears oRST[N_CH-1], go to RUN and set oREADY=1.
  - N_CH=1: oRST[0] clears at E0, the state goes WAIT to RUN directly, and oREADY rises at E0.
- RUN
  - oRST all zeros, oREADY=1. Holds until lock loss or a soft-reset request.
- Lock loss
  - Applies in WAIT, RELEASE, RUN or DRAIN: iPLL_LOCKED sampled 0.
  - On that same edge: oRST all ones, oREADY=0, state HOLD, counters cleared.
  - Lock loss has priority over iSOFT_RST.
- Soft reset
  - iSOFT_RST=1 sampled in RUN: oREADY drops on that edge. Assertion order is set by the optional feature; the sequence then re-enters HOLD and re-qualifies lock.
  - iSOFT_RST is ignored in every state other than RUN.
  - A level held high re-triggers only when RUN is next reached.
- Monotonicity
  - In RELEASE, bits only clear. In DRAIN, bits only set.
  - No channel ever releases before a lower-index channel.

Optional Feature:
- Macro: RST_SEQ_REVERSE_ASSERT_EN.
- Defined:
  - Soft reset enters DRAIN and sets oRST[N_CH-1] on the sampling edge S.
  - oRST[k] is set at S + (N_CH-1-k)*STAGGER.
  - On the edge that sets oRST[0], go to HOLD.
  - Lock loss during DRAIN still asserts all channels at once.
- Not defined:
  - Soft reset sets all oRST bits at edge S and goes straight to HOLD.
  - The DRAIN state and its encoding are not generated; oSTATE never reads 4.

Test Plan (defaults N_CH=4, LOCK_FILT=8, INIT_CYC=32, STAGGER=16; lock held high from edge 10):
1. Power-up:
   - iRESET high for edges 0..4, lock first sampled high at edge 10.
   - WAIT entered at edge 17; oRST[0..3] clear at edges 49/65/81/97.
   - oREADY=1 and oSTATE=3 from edge 97.
2. Lock glitch in HOLD:
   - Lock high for 5 cycles, low for 1, then high from edge 20.
   - WAIT entered at edge 27; no early release.
3. Lock loss mid-RELEASE:
   - Drop lock at edge 70 (channels 0,1 released).
   - Edge 70: oRST=4'b1111, oREADY=0, oSTATE=0; re-qualifies as soon as lock returns.
4. Soft reset in RUN, macro undefined:
   - iSOFT_RST pulse at edge 120.
   - Edge 120: oRST=4'b1111, oREADY=0, HOLD; releases restart at 120+7+32=159, then 175/191/207.
5. Soft reset, macro defined:
   - Pulse at edge 120.
   - oRST[3] set at 120, [2] at 136, [1] at 152, [0] at 168, HOLD at 168.
   - Lock loss injected at 140 instead: oRST=4'b1111 at 140.
6. Priority and ignore:
   - iSOFT_RST and lock-low together in RUN: HOLD, all channels asserted at once in both macro builds.
   - iSOFT_RST during WAIT: no effect, timing as in test 1.
   - iRESET pulse during RUN: all asserted on that edge.
